// File: rtl/exe_mc_stage.sv
// Execute stage between ID and MEM on the valid/allowin handshake.
// Holds one instruction, issues multi-cycle ops to an external unit
// (draining its completion safely after a flush), builds store byte
// enables and lane-replicated store data with misalignment detection,
// and publishes a forwarding view of the held destination register.
module exe_mc_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 12,
  parameter int DEST_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                ds2es_valid,
  output logic                es_allowin,
  output logic                es2ms_valid,
  input  logic                ms_allowin,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [OP_W-1:0]     in_op,
  input  logic [DATA_W-1:0]   in_src1,
  input  logic [DATA_W-1:0]   in_src2,
  input  logic [DATA_W-1:0]   in_st_data,
  input  logic                in_ld,
  input  logic                in_st,
  input  logic                in_ld_unsigned,
  input  logic [1:0]          in_size,
  input  logic                in_mc,
  input  logic                in_gr_we,
  input  logic [DEST_W-1:0]   in_dest,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_src1,
  output logic [DATA_W-1:0]   alu_src2,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                mc_start,
  output logic [OP_W-1:0]     mc_op,
  output logic [DATA_W-1:0]   mc_src1,
  output logic [DATA_W-1:0]   mc_src2,
  input  logic                mc_done,
  input  logic [DATA_W-1:0]   mc_result,
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_we,
  output logic [DATA_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  output logic [PC_W-1:0]     es2ms_pc,
  output logic [DATA_W-1:0]   es2ms_result,
  output logic                es2ms_ld,
  output logic                es2ms_ld_unsigned,
  output logic [1:0]          es2ms_size,
  output logic [2:0]          es2ms_addr_lo,
  output logic                es2ms_gr_we,
  output logic [DEST_W-1:0]   es2ms_dest,
  output logic                es2ms_ale,
  output logic                fwd_valid,
  output logic [DEST_W-1:0]   fwd_dest,
  output logic                fwd_data_ok,
  output logic [DATA_W-1:0]   fwd_data
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_EXEC,
    ST_MC_WAIT,
    ST_MC_DONE,
    ST_DRAIN
  } state_t;

  // Access of 2^size bytes is misaligned when its low address bits are not zero.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = lo[0];
      2'd2:    m = |lo[1:0];
      default: m = |lo;
    endcase
    return m;
  endfunction

  // 2^size contiguous enables starting at the byte offset.
  function automatic logic [NB-1:0] byte_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  // Replicate the low 2^size bytes of the store data across the bus.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (size)
      2'd0:    w = {NB{d[7:0]}};
      2'd1:    w = {(NB/2){d[15:0]}};
      2'd2:    w = {(DATA_W/32){d[31:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  state_t state_q, state_d;

  logic [PC_W-1:0]          pc_p0_q, pc_p0_d;
  logic [OP_W-1:0]          op_p0_q, op_p0_d;
  logic signed [DATA_W-1:0] src1_p0_q, src1_p0_d;
  logic signed [DATA_W-1:0] src2_p0_q, src2_p0_d;
  logic [DATA_W-1:0]        st_data_p0_q, st_data_p0_d;
  logic                     ld_p0_q, ld_p0_d;
  logic                     st_p0_q, st_p0_d;
  logic                     ld_uns_p0_q, ld_uns_p0_d;
  logic [1:0]               size_p0_q, size_p0_d;
  logic                     mc_p0_q, mc_p0_d;
  logic                     gr_we_p0_q, gr_we_p0_d;
  logic [DEST_W-1:0]        dest_p0_q, dest_p0_d;
  logic signed [DATA_W-1:0] mc_res_p0_q, mc_res_p0_d;
  logic                     first_p0_q, first_p0_d;

  logic vld_p0;
  logic ready_go;
  logic accept;
  logic mem_op;
  logic ale;
  logic in_exec;

  assign vld_p0     = (state_q != ST_EMPTY) && (state_q != ST_DRAIN);
  assign ready_go   = (state_q == ST_EXEC) || (state_q == ST_MC_DONE);
  assign in_exec    = (state_q == ST_EXEC);
  assign es_allowin = ((state_q == ST_EMPTY) || (ready_go && ms_allowin)) && (state_q != ST_DRAIN);
  assign accept     = ds2es_valid && es_allowin && !flush;
  assign mem_op     = ld_p0_q || st_p0_q;
  assign ale        = in_exec && mem_op && misaligned(size_p0_q, alu_result[2:0]);

  // Next state: flush wins; an outstanding multi-cycle op must drain its done pulse.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      case (state_q)
        ST_MC_WAIT: state_d = mc_done ? ST_EMPTY : ST_DRAIN;
        ST_DRAIN:   state_d = mc_done ? ST_EMPTY : ST_DRAIN;
        default:    state_d = ST_EMPTY;
      endcase
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) state_d = in_mc ? ST_MC_WAIT : ST_EXEC;
        end
        ST_EXEC, ST_MC_DONE: begin
          if (ms_allowin) begin
            if (accept) state_d = in_mc ? ST_MC_WAIT : ST_EXEC;
            else        state_d = ST_EMPTY;
          end
        end
        ST_MC_WAIT: begin
          if (mc_done) state_d = ST_MC_DONE;
        end
        ST_DRAIN: begin
          if (mc_done) state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stage register capture on accept; multi-cycle result latched on its done pulse.
  always_comb begin
    pc_p0_d      = pc_p0_q;
    op_p0_d      = op_p0_q;
    src1_p0_d    = src1_p0_q;
    src2_p0_d    = src2_p0_q;
    st_data_p0_d = st_data_p0_q;
    ld_p0_d      = ld_p0_q;
    st_p0_d      = st_p0_q;
    ld_uns_p0_d  = ld_uns_p0_q;
    size_p0_d    = size_p0_q;
    mc_p0_d      = mc_p0_q;
    gr_we_p0_d   = gr_we_p0_q;
    dest_p0_d    = dest_p0_q;
    mc_res_p0_d  = mc_res_p0_q;
    first_p0_d   = 1'b0;
    if (accept) begin
      pc_p0_d      = in_pc;
      op_p0_d      = in_op;
      src1_p0_d    = in_src1;
      src2_p0_d    = in_src2;
      st_data_p0_d = in_st_data;
      ld_p0_d      = in_ld;
      st_p0_d      = in_st;
      ld_uns_p0_d  = in_ld_unsigned;
      size_p0_d    = in_size;
      mc_p0_d      = in_mc;
      gr_we_p0_d   = in_gr_we;
      dest_p0_d    = in_dest;
      first_p0_d   = in_mc;
    end
    if ((state_q == ST_MC_WAIT) && mc_done && !flush) begin
      mc_res_p0_d = mc_result;
    end
  end

  // ---- ID -> EX stage boundary ----
  // State and stage registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      pc_p0_q      <= '0;
      op_p0_q      <= '0;
      src1_p0_q    <= '0;
      src2_p0_q    <= '0;
      st_data_p0_q <= '0;
      ld_p0_q      <= 1'b0;
      st_p0_q      <= 1'b0;
      ld_uns_p0_q  <= 1'b0;
      size_p0_q    <= '0;
      mc_p0_q      <= 1'b0;
      gr_we_p0_q   <= 1'b0;
      dest_p0_q    <= '0;
      mc_res_p0_q  <= '0;
      first_p0_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_p0_q      <= pc_p0_d;
      op_p0_q      <= op_p0_d;
      src1_p0_q    <= src1_p0_d;
      src2_p0_q    <= src2_p0_d;
      st_data_p0_q <= st_data_p0_d;
      ld_p0_q      <= ld_p0_d;
      st_p0_q      <= st_p0_d;
      ld_uns_p0_q  <= ld_uns_p0_d;
      size_p0_q    <= size_p0_d;
      mc_p0_q      <= mc_p0_d;
      gr_we_p0_q   <= gr_we_p0_d;
      dest_p0_q    <= dest_p0_d;
      mc_res_p0_q  <= mc_res_p0_d;
      first_p0_q   <= first_p0_d;
    end
  end

  // ---- EX -> MEM stage boundary ----
  assign alu_op   = op_p0_q;
  assign alu_src1 = src1_p0_q;
  assign alu_src2 = src2_p0_q;

  assign mc_start = (state_q == ST_MC_WAIT) && first_p0_q;
  assign mc_op    = op_p0_q;
  assign mc_src1  = src1_p0_q;
  assign mc_src2  = src2_p0_q;

  assign data_sram_en    = mem_op && in_exec && ms_allowin && !ale && !flush;
  assign data_sram_we    = (st_p0_q && in_exec && !ale) ? byte_mask(size_p0_q, alu_result[OFF_W-1:0]) : '0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = lane_data(size_p0_q, st_data_p0_q);

  assign es2ms_valid       = vld_p0 && ready_go && !flush;
  assign es2ms_pc          = pc_p0_q;
  assign es2ms_result      = mc_p0_q ? mc_res_p0_q : alu_result;
  assign es2ms_ld          = ld_p0_q;
  assign es2ms_ld_unsigned = ld_uns_p0_q;
  assign es2ms_size        = size_p0_q;
  assign es2ms_addr_lo     = alu_result[2:0];
  assign es2ms_gr_we       = gr_we_p0_q && !ale;
  assign es2ms_dest        = dest_p0_q;
  assign es2ms_ale         = ale;

  assign fwd_valid   = vld_p0 && gr_we_p0_q;
  assign fwd_dest    = dest_p0_q;
  assign fwd_data_ok = fwd_valid && !ld_p0_q && ready_go;
  assign fwd_data    = es2ms_result;

endmodule

// File: tb/tb_exe_mc_stage.sv
// Randomised scoreboard bench for exe_mc_stage: a driver pushes the
// expected response of every accepted instruction, a monitor pops and
// compares whenever MEM takes a result. A second 64-bit instance covers
// dword stores.
module tb_exe_mc_stage;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int OW = 12;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush, ds2es_valid, es_allowin, es2ms_valid, ms_allowin;
  logic [PW-1:0] in_pc;
  logic [OW-1:0] in_op;
  logic [DW-1:0] in_src1, in_src2, in_st_data;
  logic in_ld, in_st, in_ld_unsigned, in_mc, in_gr_we;
  logic [1:0] in_size;
  logic [RW-1:0] in_dest;
  logic [OW-1:0] alu_op, mc_op;
  logic [DW-1:0] alu_src1, alu_src2, alu_result, mc_src1, mc_src2, mc_result;
  logic mc_start, mc_done, data_sram_en;
  logic [DW/8-1:0] data_sram_we;
  logic [DW-1:0] data_sram_addr, data_sram_wdata, es2ms_result, fwd_data;
  logic [PW-1:0] es2ms_pc;
  logic es2ms_ld, es2ms_ld_unsigned, es2ms_gr_we, es2ms_ale, fwd_valid, fwd_data_ok;
  logic [1:0] es2ms_size;
  logic [2:0] es2ms_addr_lo;
  logic [RW-1:0] es2ms_dest, fwd_dest;

  exe_mc_stage #(.DATA_W(DW), .PC_W(PW), .OP_W(OW), .DEST_W(RW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .ds2es_valid(ds2es_valid), .es_allowin(es_allowin),
    .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin), .in_pc(in_pc), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_st_data(in_st_data), .in_ld(in_ld), .in_st(in_st),
    .in_ld_unsigned(in_ld_unsigned), .in_size(in_size), .in_mc(in_mc), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .mc_start(mc_start), .mc_op(mc_op), .mc_src1(mc_src1),
    .mc_src2(mc_src2), .mc_done(mc_done), .mc_result(mc_result), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es2ms_pc(es2ms_pc), .es2ms_result(es2ms_result), .es2ms_ld(es2ms_ld),
    .es2ms_ld_unsigned(es2ms_ld_unsigned), .es2ms_size(es2ms_size), .es2ms_addr_lo(es2ms_addr_lo),
    .es2ms_gr_we(es2ms_gr_we), .es2ms_dest(es2ms_dest), .es2ms_ale(es2ms_ale),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data)
  );

  // 64-bit instance, used only for dword/word/byte store lanes.
  logic v_w, allowin_w, valid_w, st_w, gr_we_w, mc_start_w, en_w, ale_w, gr_we_out_w;
  logic [1:0] size_w, size_out_w;
  logic [63:0] s1_w, sd_w, alu_s1_w, alu_s2_w, alu_res_w, mc_s1_w, mc_s2_w, addr_w, wdata_w, res_w, fwd_data_w;
  logic [7:0] we_w;
  logic [OW-1:0] alu_op_w, mc_op_w;
  logic [PW-1:0] pc_out_w;
  logic ld_out_w, ldu_out_w, fwd_valid_w, fwd_ok_w;
  logic [2:0] lo_w;
  logic [RW-1:0] dest_out_w, fwd_dest_w;
  assign alu_res_w = alu_s1_w + alu_s2_w;

  exe_mc_stage #(.DATA_W(64), .PC_W(PW), .OP_W(OW), .DEST_W(RW)) u_dut64 (
    .clk(clk), .reset(reset), .flush(1'b0), .ds2es_valid(v_w), .es_allowin(allowin_w),
    .es2ms_valid(valid_w), .ms_allowin(1'b1), .in_pc(32'h0), .in_op(12'h0),
    .in_src1(s1_w), .in_src2(64'h0), .in_st_data(sd_w), .in_ld(1'b0), .in_st(st_w),
    .in_ld_unsigned(1'b0), .in_size(size_w), .in_mc(1'b0), .in_gr_we(gr_we_w),
    .in_dest(5'd3), .alu_op(alu_op_w), .alu_src1(alu_s1_w), .alu_src2(alu_s2_w),
    .alu_result(alu_res_w), .mc_start(mc_start_w), .mc_op(mc_op_w), .mc_src1(mc_s1_w),
    .mc_src2(mc_s2_w), .mc_done(1'b0), .mc_result(64'h0), .data_sram_en(en_w),
    .data_sram_we(we_w), .data_sram_addr(addr_w), .data_sram_wdata(wdata_w),
    .es2ms_pc(pc_out_w), .es2ms_result(res_w), .es2ms_ld(ld_out_w),
    .es2ms_ld_unsigned(ldu_out_w), .es2ms_size(size_out_w), .es2ms_addr_lo(lo_w),
    .es2ms_gr_we(gr_we_out_w), .es2ms_dest(dest_out_w), .es2ms_ale(ale_w),
    .fwd_valid(fwd_valid_w), .fwd_dest(fwd_dest_w), .fwd_data_ok(fwd_ok_w), .fwd_data(fwd_data_w)
  );

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [OW-1:0] op;
    logic [DW-1:0] s1, s2, sd;
    logic ld, st, lu, mc, we;
    logic [1:0] size;
    logic [RW-1:0] dest;
  } tx_t;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [RW-1:0] dest;
    logic [DW-1:0] res, wdata;
    logic gr_we, ale, en, fv, fok, chk_wd;
    logic [3:0] be;
  } exp_t;

  exp_t sb[$];
  int checks = 0, fails = 0;
  int mc_acc = 0, mc_starts = 0, en_seen = 0, en_exp = 0;
  logic mc_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // External single-cycle ALU the stage feeds.
  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      12'd0:   return a + b;
      12'd1:   return a - b;
      12'd2:   return a ^ b;
      default: return a | b;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_op, alu_src1, alu_src2);

  // Reference: what MEM should see for one instruction.
  function automatic exp_t model(input tx_t t);
    exp_t e;
    logic [DW-1:0] addr;
    int nb, off;
    addr     = alu_fn(t.op, t.s1, t.s2);
    nb       = 1 << t.size;
    off      = int'(addr % 4);
    e        = '0;
    e.pc     = t.pc;
    e.dest   = t.dest;
    e.res    = t.mc ? t.s1 * t.s2 : addr;
    e.ale    = (t.ld || t.st) && ((addr % nb) != 0);
    e.en     = (t.ld || t.st) && !e.ale;
    e.chk_wd = t.st && !e.ale;
    for (int i = 0; i < 4; i++) begin
      if (e.chk_wd && i >= off && i < off + nb) e.be[i] = 1'b1;
      e.wdata[8*i +: 8] = t.sd[8*(i % nb) +: 8];
    end
    e.gr_we  = t.we && !e.ale;
    e.fv     = t.we;
    e.fok    = t.we && !t.ld;
    return e;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    int k;
    k      = int'($urandom % 8);
    t      = '0;
    t.pc   = $urandom;
    t.dest = RW'($urandom);
    t.sd   = $urandom;
    t.s1   = $urandom;
    t.s2   = $urandom;
    t.lu   = 1'($urandom);
    t.size = 2'($urandom % 3);
    t.we   = 1'($urandom);
    if (k < 4) begin
      t.op = OW'($urandom % 4);
    end else if (k == 4) begin
      t.mc = 1'b1; t.op = 12'h20; t.we = 1'b1;
    end else if (k == 5) begin
      t.ld = 1'b1; t.s2 = $urandom % 8; t.we = 1'b1;
    end else begin
      t.st = 1'b1; t.s2 = $urandom % 8; t.we = 1'b0;
    end
    return t;
  endfunction

  // One cycle of ID stimulus; records the expected result on acceptance.
  task automatic apply(input tx_t t, input logic v, input logic ms, input logic fl, output logic acc);
    @(posedge clk); #1;
    ds2es_valid = v; ms_allowin = ms; flush = fl;
    in_pc = t.pc; in_op = t.op; in_src1 = t.s1; in_src2 = t.s2; in_st_data = t.sd;
    in_ld = t.ld; in_st = t.st; in_ld_unsigned = t.lu; in_size = t.size;
    in_mc = t.mc; in_gr_we = t.we; in_dest = t.dest;
    @(negedge clk);
    acc = v && es_allowin && !fl;
    if (fl) sb.delete();
    else if (acc) begin
      sb.push_back(model(t));
      if (t.mc) mc_acc++;
    end
  endtask

  task automatic send(input tx_t t);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) apply(t, 1'b1, 1'b1, 1'b0, acc);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic ms);
    tx_t z;
    logic acc;
    z = '0;
    for (int i = 0; i < n; i++) apply(z, 1'b0, ms, 1'b0, acc);
  endtask

  // Multi-cycle unit: completes 1..4 cycles after the start pulse.
  initial begin
    logic [DW-1:0] a, b;
    int d;
    mc_done = 1'b0;
    mc_result = '0;
    forever begin
      @(negedge clk);
      if (mc_start && !reset) begin
        a = mc_src1; b = mc_src2; mc_busy = 1'b1;
        d = int'($urandom_range(1, 4));
        repeat (d) @(posedge clk);
        #1 mc_done = 1'b1; mc_result = a * b;
        @(posedge clk);
        #1 mc_done = 1'b0; mc_result = $urandom; mc_busy = 1'b0;
      end
    end
  end

  // Monitor: compares each result MEM takes against the scoreboard head.
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_res = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mc_start) mc_starts++;
      if (data_sram_en) en_seen++;
      if (mc_start || mc_busy) chk("allowin_while_mc", 64'(es_allowin), 64'd0);
      if (prev_stall && !flush) begin
        chk("stall_hold_valid", 64'(es2ms_valid), 64'd1);
        chk("stall_hold_result", 64'(es2ms_result), 64'(prev_res));
      end
      if (es2ms_valid && !ms_allowin) chk("stall_no_en", 64'(data_sram_en), 64'd0);
      prev_stall = es2ms_valid && !ms_allowin;
      prev_res   = es2ms_result;
      if (es2ms_valid && ms_allowin) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          en_exp += int'(e.en);
          chk("result", 64'(es2ms_result), 64'(e.res));
          chk("pc", 64'(es2ms_pc), 64'(e.pc));
          chk("dest", 64'(es2ms_dest), 64'(e.dest));
          chk("gr_we", 64'(es2ms_gr_we), 64'(e.gr_we));
          chk("ale", 64'(es2ms_ale), 64'(e.ale));
          chk("sram_en", 64'(data_sram_en), 64'(e.en));
          chk("sram_we", 64'(data_sram_we), 64'(e.be));
          if (e.chk_wd) chk("sram_wdata", 64'(data_sram_wdata), 64'(e.wdata));
          chk("fwd_valid", 64'(fwd_valid), 64'(e.fv));
          chk("fwd_data_ok", 64'(fwd_data_ok), 64'(e.fok));
          chk("fwd_data", 64'(fwd_data), 64'(e.res));
        end
      end
    end
  end

  task automatic store64(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] we_req, input logic ale_req, input logic [63:0] wd_req);
    @(posedge clk); #1;
    v_w = 1'b1; st_w = 1'b1; gr_we_w = 1'b1; size_w = sz; s1_w = a; sd_w = d;
    @(posedge clk); #1;
    v_w = 1'b0;
    @(negedge clk);
    chk("w64_valid", 64'(valid_w), 64'd1);
    chk("w64_we", 64'(we_w), 64'(we_req));
    chk("w64_ale", 64'(ale_w), 64'(ale_req));
    chk("w64_en", 64'(en_w), 64'(!ale_req));
    chk("w64_gr_we", 64'(gr_we_out_w), 64'(!ale_req));
    if (!ale_req) chk("w64_wdata", wdata_w, wd_req);
  endtask

  initial begin
    tx_t t;
    logic acc;
    reset = 1'b1; flush = 1'b0; ds2es_valid = 1'b0; ms_allowin = 1'b1;
    in_pc = '0; in_op = '0; in_src1 = '0; in_src2 = '0; in_st_data = '0;
    in_ld = 1'b0; in_st = 1'b0; in_ld_unsigned = 1'b0; in_size = '0;
    in_mc = 1'b0; in_gr_we = 1'b0; in_dest = '0;
    v_w = 1'b0; st_w = 1'b0; gr_we_w = 1'b0; size_w = '0; s1_w = '0; sd_w = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 64'(es_allowin), 64'd1);
    chk("rst_valid", 64'(es2ms_valid), 64'd0);
    chk("rst_mc_start", 64'(mc_start), 64'd0);
    chk("rst_en", 64'(data_sram_en), 64'd0);
    chk("rst_we", 64'(data_sram_we), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_fwd_ok", 64'(fwd_data_ok), 64'd0);
    chk("rst_ale", 64'(es2ms_ale), 64'd0);
    chk("rst_allowin64", 64'(allowin_w), 64'd1);

    // back-to-back adds
    for (int i = 0; i < 3; i++) begin
      t = '0; t.pc = 32'h100 + 32'(4*i); t.s1 = 32'(i * 7 + 1); t.s2 = 32'h10; t.we = 1'b1; t.dest = RW'(i + 1);
      send(t);
    end
    // st.h aligned and misaligned
    t = '0; t.st = 1'b1; t.size = 2'd1; t.s1 = 32'h1000; t.s2 = 32'd2; t.sd = 32'h0000ABCD; t.we = 1'b1;
    send(t);
    t.s2 = 32'd1;
    send(t);
    // mul producing 0x12345678
    t = '0; t.mc = 1'b1; t.op = 12'h20; t.s1 = 32'h12345678; t.s2 = 32'd1; t.we = 1'b1; t.dest = 5'd9;
    send(t);
    idle(8, 1'b1);
    // load stalled by MEM for three cycles
    t = '0; t.ld = 1'b1; t.size = 2'd2; t.s1 = 32'h2000; t.s2 = 32'd4; t.we = 1'b1; t.dest = 5'd4;
    send(t);
    idle(3, 1'b0);
    idle(2, 1'b1);
    // flush in the second MC_WAIT cycle
    t = '0; t.mc = 1'b1; t.op = 12'h20; t.s1 = 32'd6; t.s2 = 32'd7; t.we = 1'b1;
    send(t);
    idle(1, 1'b1);
    apply(t, 1'b0, 1'b1, 1'b1, acc);
    idle(8, 1'b1);

    // randomised traffic with stalls and flushes
    for (int c = 0; c < 1500; c++) begin
      apply(rand_tx(), 1'($urandom % 4 != 0), 1'($urandom % 4 != 0), 1'($urandom % 25 == 0), acc);
    end
    idle(20, 1'b1);
    chk("queue_empty", 64'(sb.size()), 64'd0);
    chk("mc_start_count", 64'(mc_starts), 64'(mc_acc));
    chk("sram_en_count", 64'(en_seen), 64'(en_exp));

    // 64-bit lanes
    store64(2'd3, 64'h8, 64'h1122334455667788, 8'hFF, 1'b0, 64'h1122334455667788);
    store64(2'd3, 64'hC, 64'h1122334455667788, 8'h00, 1'b1, 64'h0);
    store64(2'd2, 64'hC, 64'h1122334455667788, 8'hF0, 1'b0, 64'h5566778855667788);
    store64(2'd0, 64'h5, 64'h1122334455667788, 8'h20, 1'b0, 64'h8888888888888888);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
